// File: rtl/vote_logger_param_if.sv
// vote_logger_param_if: bundles the ballot handshake, tally outputs and
// readout port of vote_logger_param.
//   master : ballot controller / result path (drives mode, ballot_open,
//            clear_counts, vote_req, rd_sel; observes everything else)
//   slave  : the vote logger itself
interface vote_logger_param_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int TOT_W    = CNT_W + $clog2(NUM_CAND)
);
    localparam int SEL_W = $clog2(NUM_CAND);

    logic                      mode;
    logic                      ballot_open;
    logic                      clear_counts;
    logic [NUM_CAND-1:0]       vote_req;
    logic [SEL_W-1:0]          rd_sel;
    logic                      ballot_armed;
    logic                      vote_ack;
    logic                      vote_err;
    logic [NUM_CAND*CNT_W-1:0] counts;
    logic [TOT_W-1:0]          total_votes;
    logic [NUM_CAND-1:0]       sat;
    logic [CNT_W-1:0]          rd_count;

    modport master (
        output mode, ballot_open, clear_counts, vote_req, rd_sel,
        input  ballot_armed, vote_ack, vote_err, counts, total_votes, sat, rd_count
    );

    modport slave (
        input  mode, ballot_open, clear_counts, vote_req, rd_sel,
        output ballot_armed, vote_ack, vote_err, counts, total_votes, sat, rd_count
    );
endinterface

// File: rtl/vote_logger_param.sv
// vote_logger_param: parametrised vote counter.
// One vote per ballot: ballot_open arms the logger (voting mode only), a
// one-hot vote_req is tallied and acknowledged, multi-hot requests are
// rejected with vote_err, and the logger then waits for all buttons to be
// released before returning to idle. Tallies and total saturate; sat flags
// are sticky until cleared in result mode. rd_count is a registered read of
// the tally selected by rd_sel (0 for out-of-range indices).
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - vote_logger_param_if slave modport (handshake, tallies, readout)
module vote_logger_param #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int TOT_W    = CNT_W + $clog2(NUM_CAND)
) (
    input  logic                  clock,
    input  logic                  reset,
    vote_logger_param_if.slave    bus
);
    localparam int SEL_W = $clog2(NUM_CAND);
    localparam logic [NUM_CAND-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED
    } state_t;

    state_t                    state;
    logic                      armed_r;
    logic                      ack_r;
    logic                      err_r;
    logic [CNT_W-1:0]          tally [NUM_CAND];
    logic [TOT_W-1:0]          total_r;
    logic [NUM_CAND-1:0]       sat_r;
    logic [CNT_W-1:0]          rd_r;
    logic [CNT_W-1:0]          rd_next;
    logic [NUM_CAND*CNT_W-1:0] counts_flat;

    logic any_req;
    logic multi_hot;
    logic accept;
    logic reject;
    logic clear_now;

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign any_req   = |bus.vote_req;
    assign multi_hot = |(bus.vote_req & (bus.vote_req - ONE));
    assign accept    = (state == ARMED) && !bus.mode && any_req && !multi_hot;
    assign reject    = (state == ARMED) && !bus.mode && multi_hot;
    assign clear_now = bus.mode && bus.clear_counts;

    // Ballot FSM with registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            armed_r <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ack_r <= accept;
            err_r <= reject;
            case (state)
                IDLE: begin
                    if (bus.ballot_open && !bus.mode) begin
                        state   <= ARMED;
                        armed_r <= 1'b1;
                    end
                end
                ARMED: begin
                    // Switching to result mode cancels the open ballot.
                    if (bus.mode) begin
                        state   <= IDLE;
                        armed_r <= 1'b0;
                    end else if (accept) begin
                        state   <= LOCKED;
                        armed_r <= 1'b0;
                    end
                end
                LOCKED: begin
                    // Wait for button release so a held button counts once.
                    if (!any_req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    armed_r <= 1'b0;
                end
            endcase
        end
    end

    // Tallies, total and sticky saturation flags. Clear beats increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
            total_r <= '0;
            sat_r   <= '0;
        end else if (clear_now) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
            total_r <= '0;
            sat_r   <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                if (bus.vote_req[i]) begin
                    if (tally[i] == '1) begin
                        sat_r[i] <= 1'b1;
                    end else begin
                        tally[i] <= tally[i] + 1'b1;
                    end
                end
            end
            if (total_r != '1) begin
                total_r <= total_r + 1'b1;
            end
        end
    end

    // Indexed readout; unmatched (out-of-range) indices fall through to 0.
    always_comb begin
        rd_next = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (bus.rd_sel == SEL_W'(i)) begin
                rd_next = tally[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_r <= '0;
        end else begin
            rd_r <= rd_next;
        end
    end

    always_comb begin
        counts_flat = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            counts_flat[i*CNT_W +: CNT_W] = tally[i];
        end
    end

    assign bus.ballot_armed = armed_r;
    assign bus.vote_ack     = ack_r;
    assign bus.vote_err     = err_r;
    assign bus.counts       = counts_flat;
    assign bus.total_votes  = total_r;
    assign bus.sat          = sat_r;
    assign bus.rd_count     = rd_r;
endmodule

// File: doc/vote_logger_param.md
# vote_logger_param

Parametrised vote counter for the voting machine: NUM_CAND candidates, CNT_W-bit per-candidate tallies, a running total, and a one-vote-per-ballot handshake. Sits between the ballot controller (which opens a ballot) and the result/display path (which reads tallies in result mode). It adds several behaviours not present in the current logger: one-hot vote checking, saturating counters, a synchronous clear in result mode, and registered indexed readout.

## Interface
- NUM_CAND, default 4: number of candidates (2..16).
- CNT_W, default 8: per-candidate tally width.
- TOT_W, default CNT_W+$clog2(NUM_CAND): total-vote counter width.
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- mode  in  1  0 = voting, 1 = result/readout.
- ballot_open  in  1  one-cycle pulse from the controller authorising one vote.
- clear_counts  in  1  synchronous tally clear; honoured only when mode=1.
- vote_req  in  NUM_CAND  candidate buttons, bit i = candidate i; a legal vote is exactly one bit high.
- rd_sel  in  $clog2(NUM_CAND)  candidate index for readout.
- ballot_armed  out  1  high while a ballot is open (state ARMED).
- vote_ack  out  1  one-cycle pulse: a vote was recorded.
- vote_err  out  1  one-cycle pulse: a multi-hot vote_req was rejected.
- counts  out  NUM_CAND*CNT_W  flattened tallies; candidate i occupies bits [i*CNT_W +: CNT_W].
- total_votes  out  TOT_W  count of all recorded votes.
- sat  out  NUM_CAND  sticky per-candidate saturation flags.
- rd_count  out  CNT_W  registered tally of candidate rd_sel.

## Operation
- Reset values: state IDLE; counts, total_votes, sat, rd_count all 0; ballot_armed, vote_ack, vote_err 0.
- IDLE:
  - ballot_open=1 and mode=0 -> ARMED.
  - ballot_open in mode=1 is ignored.
- ARMED:
  - mode=1 -> IDLE. The ballot is cancelled and no vote is recorded.
  - vote_req one-hot at candidate i -> tally i +1 and total +1, vote_ack pulse, go to LOCKED.
  - vote_req with 2 or more bits high -> vote_err pulse, nothing counted, stay ARMED.
  - vote_req all zero -> stay ARMED.
- LOCKED: stay until vote_req is all zero, then go to IDLE. This stops a held button from being counted twice.
- ballot_open while in ARMED or LOCKED is ignored. Ballots do not queue.
- Saturation:
  - A tally at 2^CNT_W-1 holds its value and sets sat[i].
  - The vote is still acknowledged.
  - total_votes saturates at 2^TOT_W-1 in the same way.
- clear_counts=1 with mode=1: counts, total_votes and sat go to 0 at the next edge. State is unaffected. With mode=0, clear_counts is ignored.
- Priority: reset > clear_counts > vote increment.
- Readout:
  - rd_count <= tally[rd_sel] on every edge, in either mode.
  - rd_sel >= NUM_CAND returns 0.

## Timing
- vote_req is sampled at the rising edge while in ARMED. On that same edge:
  - the tally and total update;
  - vote_ack goes high for exactly the following cycle;
  - state moves to LOCKED.
- Updated counts become visible in the same cycle vote_ack is high.
- vote_err also goes high for the cycle after the sampling edge. Back-to-back multi-hot cycles give back-to-back err pulses.
- ballot_armed rises the cycle after the edge that samples ballot_open.
- Latencies:
  - ballot_open pulse to earliest accept edge: 1 cycle.
  - Minimum time between accepted votes: 3 cycles (LOCKED needs one zero cycle, then IDLE, then a new ballot_open, then ARMED).
- rd_count latency is 1 cycle from rd_sel. It also reflects a tally update one cycle after that update.
- Asserting reset mid-ballot (ARMED or LOCKED) returns the block to IDLE at once and drops pending pulses. A vote sampled on the edge coincident with reset assertion is lost.
- vote_ack and vote_err are never high in the same cycle.

## Test plan
- Reset, then ballot_open, then vote_req=4'b0100 -> the cycle after the sample edge shows vote_ack=1, tally2=1, total_votes=1. vote_req is then held for 5 cycles -> no further increments; state leaves LOCKED only after vote_req=0.
- Ballot armed, vote_req=4'b0011 -> vote_err=1 for one cycle, all tallies unchanged. Next, vote_req=4'b0001 -> tally0=1, vote_ack=1.
- Drive 260 ballots for candidate 1 with CNT_W=8 -> tally1=255, sat[1]=1, total_votes=260, 260 ack pulses.
- mode=1 and clear_counts=1 -> all tallies, total and sat are 0 on the next cycle. Repeating the same with mode=0 -> nothing clears.
- ballot_open, then mode=1 before any vote -> ballot_armed falls and the counts are unchanged. Separately, assert reset while ARMED -> all outputs go to 0 immediately.
- NUM_CAND=6 instance: rd_sel=5 after 3 votes for candidate 5 -> rd_count=3 one cycle later. rd_sel=7 -> rd_count=0.
